// File: rtl/mul_tree_bfp_drain_pkg.sv
// rtl/mul_tree_bfp_drain_pkg.sv - shared constants for the bf16 block-floating-point drain
//
// Purpose: state encodings, bf16 field layout, lane count and the default
// output lane width shared by mul_tree_bfp_drain and bf16_lane_align.
// Ports: none (package).
package mul_tree_bfp_drain_pkg;

   localparam int LANES    = 4;
   localparam int FX_W_DEF = 16;

   // bf16 field layout: {sign, exponent[7:0], mantissa[6:0]}
   localparam int BF_SIGN_BIT = 15;
   localparam int BF_EXP_LSB  = 7;
   localparam int BF_EXP_W    = 8;
   localparam int BF_MAN_W    = 7;

   localparam logic [1:0] ST_FILL    = 2'd0;
   localparam logic [1:0] ST_REQ_EXP = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/mul_tree_bfp_drain_lane_align.sv
// rtl/mul_tree_bfp_drain_lane_align.sv - combinational bf16 to fixed-point lane aligner
//
// Purpose: converts one bf16 lane to a signed FX_W-bit value aligned to the
// shared block exponent E. Zero/denormal inputs flush to 0; an input exponent
// above E is passed unshifted and flagged on range_err_o.
// Build option: MUL_TREE_BFP_ROUND_EN selects round half-up on the alignment
// shift; otherwise bits shifted out are truncated.
// Ports:
//   lane_i      bf16 input lane
//   exp_i       shared (biased) block exponent E
//   value_o     two's-complement aligned value
//   range_err_o lane exponent exceeded E
module bf16_lane_align
   import mul_tree_bfp_drain_pkg::*;
#(
   parameter int FX_W = FX_W_DEF
) (
   input  logic [15:0]     lane_i,
   input  logic [7:0]      exp_i,
   output logic [FX_W-1:0] value_o,
   output logic            range_err_o
);

   logic                sgn;
   logic [BF_EXP_W-1:0] e;
   logic [BF_MAN_W-1:0] m;
   logic [14:0]         full;
   logic [7:0]          sh;
   logic [14:0]         mag;
   logic [FX_W-1:0]     magx;
`ifdef MUL_TREE_BFP_ROUND_EN
   logic [3:0]          rb_idx;
`endif

   always_comb begin
      sgn  = lane_i[BF_SIGN_BIT];
      e    = lane_i[BF_EXP_LSB +: BF_EXP_W];
      m    = lane_i[0 +: BF_MAN_W];
      full = {1'b1, m, 7'b0};
      range_err_o = (e != 8'd0) && (e > exp_i);
      sh   = (e > exp_i) ? 8'd0 : (exp_i - e);
      mag  = '0;
`ifdef MUL_TREE_BFP_ROUND_EN
      rb_idx = sh[3:0] - 4'd1;
      if (e != 8'd0) begin
         if (sh == 8'd0) begin
            mag = full;
         end else if (sh <= 8'd15) begin
            // Rounding bit is the last one shifted out, so sh=15 can still give 1.
            mag = (full >> sh) + {14'd0, full[rb_idx]};
         end
      end
`else
      if (e != 8'd0 && sh < 8'd15) begin
         mag = full >> sh;
      end
`endif
      magx    = FX_W'(mag);
      value_o = sgn ? (-magx) : magx;
   end

endmodule

// File: rtl/mul_tree_bfp_drain.sv
// rtl/mul_tree_bfp_drain.sv - batch buffer and block-floating-point replay of bf16 results
//
// Purpose: captures BATCH_WORDS 64-bit result words (4 bf16 lanes each),
// requests the batch maximum exponent, then replays the batch as 4 signed
// fixed-point lanes aligned to that exponent over a valid/ready stream.
// Build option: MUL_TREE_BFP_ROUND_EN (round half-up in the lane aligner).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   res_data, res_vld               incoming result words (no backpressure)
//   max_exponent_ready/_vld, max_exponent  exponent request handshake
//   out_data, out_exp, out_vld, out_ready, out_last  aligned output stream
//   err_overflow                    sticky: dropped word or lane exponent above E
module mul_tree_bfp_drain
   import mul_tree_bfp_drain_pkg::*;
#(
   parameter int BATCH_WORDS = 16,
   parameter int LOG2_BATCH  = 4,
   parameter int FX_W        = FX_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] res_data,
   input  logic        res_vld,
   output logic        max_exponent_ready,
   input  logic [7:0]  max_exponent,
   input  logic        max_exponent_vld,
   output logic [63:0] out_data,
   output logic [7:0]  out_exp,
   output logic        out_vld,
   input  logic        out_ready,
   output logic        out_last,
   output logic        err_overflow
);

   localparam logic [LOG2_BATCH-1:0] LAST_IDX = LOG2_BATCH'(BATCH_WORDS - 1);

   logic [63:0]           buf_q [BATCH_WORDS];
   logic [1:0]            state_q, state_d;
   logic [LOG2_BATCH-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2_BATCH-1:0] rd_cnt_q, rd_cnt_d;
   logic [7:0]            exp_q, exp_d;
   logic [63:0]           out_data_q, out_data_d;
   logic                  out_vld_q, out_vld_d;
   logic                  out_last_q, out_last_d;
   logic                  err_q, err_d;
   logic                  wr_en;
   logic                  load;
   logic [63:0]           rd_word;
   logic [63:0]           conv_word;
   logic [FX_W-1:0]       lane_val [LANES];
   logic [LANES-1:0]      lane_err;

   assign rd_word = buf_q[rd_cnt_q];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bf16_lane_align #(.FX_W(FX_W)) u_align (
         .lane_i      (rd_word[16*k +: 16]),
         .exp_i       (exp_q),
         .value_o     (lane_val[k]),
         .range_err_o (lane_err[k])
      );
   end

   always_comb begin
      conv_word = '0;
      for (int k = 0; k < LANES; k++) begin
         conv_word[16*k +: 16] = 16'(lane_val[k]);
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      exp_d      = exp_q;
      out_data_d = out_data_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      load       = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (res_vld) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + 1'b1;   // wraps to 0 after the last word
               if (wr_cnt_q == LAST_IDX) begin
                  state_d = ST_REQ_EXP;
               end
            end
         end
         ST_REQ_EXP: begin
            if (max_exponent_vld) begin
               exp_d    = max_exponent;
               rd_cnt_d = '0;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // First cycle in DRAIN primes the output register; afterwards a
            // new word is loaded on every accept until the last one leaves.
            if (!out_vld_q) begin
               load = 1'b1;
            end else if (out_ready) begin
               if (out_last_q) begin
                  out_vld_d  = 1'b0;
                  out_last_d = 1'b0;
                  state_d    = ST_FILL;
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (load) begin
         out_data_d = conv_word;
         out_vld_d  = 1'b1;
         out_last_d = (rd_cnt_q == LAST_IDX);
         rd_cnt_d   = rd_cnt_q + 1'b1;
         if (|lane_err) begin
            err_d = 1'b1;
         end
      end

      // Words outside FILL are dropped, including one coinciding with the final accept.
      if (res_vld && state_q != ST_FILL) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_cnt_q] <= res_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         exp_q      <= '0;
         out_data_q <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         exp_q      <= exp_d;
         out_data_q <= out_data_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         err_q      <= err_d;
      end
   end

   assign max_exponent_ready = (state_q == ST_REQ_EXP);
   assign out_data           = out_data_q;
   assign out_exp            = exp_q;
   assign out_vld            = out_vld_q;
   assign out_last           = out_last_q;
   assign err_overflow       = err_q;

endmodule
